multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It sequences the shared datapath (PC, instruction register, single ALU, register file, unified memory) through fetch, decode, execute, memory and writeback. It holds the memory request until the memory handshake completes, decodes the immediate format, and drives the 2-bit ALU operation class into the ALU decoder.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; state forced to FETCH
- op  in  7  instruction opcode, from the instruction register
- funct3  in  3  instruction funct3; bit 0 selects beq (0) or bne (1)
- funct7b5  in  1  instruction bit 30; passed through, unused by the FSM
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  write enable, qualified by mem_req
- adrsrc  out  1  0 = PC, 1 = ALUOut drives the memory address
- irwrite  out  1  load the instruction register and oldPC
- pcwrite  out  1  load the PC from the result bus
- regwrite  out  1  register file write
- resultsrc  out  2  00 ALUOut, 01 memory data, 10 ALU result
- alusrca  out  2  00 PC, 01 oldPC, 10 rs1
- alusrcb  out  2  00 rs2, 01 immediate, 10 constant 4
- aluop  out  2  00 add, 01 subtract, 10 funct-decoded
- immsrc  out  3  000 I, 001 S, 010 B, 011 J
- illegal  out  1  core halted on an unsupported opcode

## Operation
- Moore FSM. All outputs are decoded combinationally from the state register. The exceptions are:
  - pcwrite, irwrite and branch, which are also qualified by inputs.
  - immsrc, which is decoded from op only.
- Any output not listed for a state is 0.
- States and their outputs:
  - FETCH: mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10. When mem_ready=1: irwrite=1, pcwrite=1, then go to DECODE. Otherwise stay in FETCH.
  - DECODE: alusrca=01, alusrcb=01, aluop=00 (branch/jump target into ALUOut). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALRADR (macro only)
    - anything else → HALT
  - MEMADR: alusrca=10, alusrcb=01, aluop=00. Goes to MEMREAD if op[5]=0, to MEMWRITE if op[5]=1.
  - MEMREAD: mem_req=1, adrsrc=1, resultsrc=00. Stays until mem_ready=1, then goes to MEMWB.
  - MEMWB: resultsrc=01, regwrite=1, then FETCH.
  - MEMWRITE: mem_req=1, memwrite=1, adrsrc=1. Stays until mem_ready=1, then goes to FETCH.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=10, then ALUWB.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10, then ALUWB.
  - ALUWB: resultsrc=00, regwrite=1, then FETCH.
  - BRANCH: alusrca=10, alusrcb=00, aluop=01, resultsrc=00. pcwrite = zero XOR funct3[0]. Then FETCH.
  - JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcwrite=1, then ALUWB.
  - JALRADR: alusrca=10, alusrcb=01, aluop=00, then JAL. JAL then reuses ALUOut = rs1+imm as the new PC.
  - HALT: illegal=1, all strobes 0. Terminal until reset.
- immsrc decode from op:
  - 0100011 → 001
  - 1100011 → 010
  - 1101111 → 011
  - all others, including 1100111 → 000

## Timing
- Reset:
  - state=FETCH.
  - While reset is high, mem_req, irwrite and pcwrite are forced to 0.
  - All other outputs take their FETCH values: alusrcb=10, resultsrc=10, everything else 0.
- A reset asserted mid-operation (for example in MEMREAD while waiting) abandons the access immediately. mem_req drops in the same cycle, without waiting for mem_ready.
- mem_req stays high continuously until the cycle with mem_ready=1. The request retires in that cycle.
- The address and write enable hold steady for the whole wait.
- mem_ready outside a request state is ignored.
- Latency with mem_ready tied high:
  - R-type, I-type ALU, jal, sw: 4 cycles
  - lw: 5 cycles
  - jalr: 5 cycles
  - branch: 3 cycles
- Each wait cycle on mem_ready adds exactly 1 cycle.

## Configuration
- CTRL_JALR_EN defined: opcode 1100111 is legal and follows DECODE→JALRADR→JAL→ALUWB.
- CTRL_JALR_EN undefined: the JALRADR state is not compiled, and 1100111 goes to HALT with illegal=1.

## Structure
- Package riscv_ctrl_pkg holds:
  - the state enum
  - opcode localparams
  - aluop, resultsrc, alusrca, alusrcb and immsrc encodings
- One natural sub-module: imm_src_dec, the combinational op→immsrc decode.
- The FSM stays in a single module with two processes: the state register and the next-state/output logic.

## Test plan
- Reset: assert reset with mem_ready=1. Required: mem_req=0, pcwrite=0, irwrite=0. After release, the first edge with mem_ready=1 gives irwrite=1 and pcwrite=1.
- addi 0x00500093 with mem_ready=1: states FETCH→DECODE→EXECUTEI→ALUWB. aluop=10 in EXECUTEI, regwrite=1 only in cycle 4.
- lw 0x0000A103 with mem_ready low for 3 cycles in MEMREAD: mem_req and adrsrc held high for 4 cycles, then MEMWB with resultsrc=01.
- Branches:
  - beq 0x00208463 with zero=1: pcwrite=1 in BRANCH.
  - Same with zero=0: pcwrite=0.
  - bne 0x00209463 with zero=0: pcwrite=1.
- Opcode 0x7F: DECODE→HALT, illegal=1 held for 10+ cycles, no strobes. Reset returns the FSM to FETCH.
- jalr 0x000080E7: with the macro, the sequence is JALRADR→JAL (pcwrite=1)→ALUWB. Without the macro, the FSM goes to HALT.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// Optional feature macro: CTRL_JALR_EN (adds the JALRADR state and jalr support).
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_HALT
`ifdef CTRL_JALR_EN
        , S_JALRADR
`endif
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    // Opcode dispatch out of DECODE; unsupported opcodes halt the core.
    function automatic state_e decode_next(input logic [6:0] op);
        state_e nxt;
        unique case (op)
            OP_LOAD,
            OP_STORE:  nxt = S_MEMADR;
            OP_RTYPE:  nxt = S_EXECUTER;
            OP_ITYPE:  nxt = S_EXECUTEI;
            OP_BRANCH: nxt = S_BRANCH;
            OP_JAL:    nxt = S_JAL;
`ifdef CTRL_JALR_EN
            OP_JALR:   nxt = S_JALRADR;
`endif
            default:   nxt = S_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified-memory request bundle between the control FSM and memory.
// Request holds until the memory raises mem_ready for one cycle.
interface multicycle_ctrl_if;

    logic mem_req;
    logic memwrite;
    logic adrsrc;
    logic mem_ready;

    modport master (
        output mem_req,
        output memwrite,
        output adrsrc,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  memwrite,
        input  adrsrc,
        output mem_ready
    );

endinterface

// File: rtl/multicycle_ctrl_imm_src_dec.sv
// Immediate-format select decoded from the opcode alone.
// jalr and all I-type style opcodes fall through to the I format.
module imm_src_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] immsrc
);

    // Opcode to immediate format
    always_comb begin
        immsrc = IMM_I;
        unique case (op)
            OP_STORE:  immsrc = IMM_S;
            OP_BRANCH: immsrc = IMM_B;
            OP_JAL:    immsrc = IMM_J;
            default:   immsrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core (Moore, two-process).
// Optional feature macro: CTRL_JALR_EN enables jalr via the JALRADR state.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    multicycle_ctrl_if.master     mem,
    output logic                  irwrite,
    output logic                  pcwrite,
    output logic                  regwrite,
    output logic [1:0]            resultsrc,
    output logic [1:0]            alusrca,
    output logic [1:0]            alusrcb,
    output logic [1:0]            aluop,
    output logic [2:0]            immsrc,
    output logic                  illegal
);

    state_e state_q;
    state_e state_d;

    logic mem_req_c;
    logic memwrite_c;
    logic adrsrc_c;

    // funct7b5 and the upper funct3 bits belong to the ALU decoder
    logic unused_ok;
    assign unused_ok = ^{funct7b5, funct3[2:1]};

    imm_src_dec u_imm_src_dec (
        .op     (op),
        .immsrc (immsrc)
    );

    // State register; reset lands in FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state datapath controls
    always_comb begin
        state_d    = state_q;
        mem_req_c  = 1'b0;
        memwrite_c = 1'b0;
        adrsrc_c   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regwrite   = 1'b0;
        resultsrc  = RES_ALUOUT;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_RS2;
        aluop      = ALUOP_ADD;
        illegal    = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                if (mem.mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                state_d = decode_next(op);
            end
            S_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adrsrc_c  = 1'b1;
                if (mem.mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                resultsrc = RES_MEMDATA;
                regwrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c  = 1'b1;
                memwrite_c = 1'b1;
                adrsrc_c   = 1'b1;
                if (mem.mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_RS2;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_RS2;
                aluop   = ALUOP_SUB;
                pcwrite = zero ^ funct3[0];
                state_d = S_FETCH;
            end
            S_JAL: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_FOUR;
                pcwrite = 1'b1;
                state_d = S_ALUWB;
            end
`ifdef CTRL_JALR_EN
            S_JALRADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                state_d = S_JAL;
            end
`endif
            S_HALT: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        // An asserted reset abandons any access in the same cycle
        if (reset) begin
            mem_req_c = 1'b0;
            irwrite   = 1'b0;
            pcwrite   = 1'b0;
        end
    end

    assign mem.mem_req  = mem_req_c;
    assign mem.memwrite = memwrite_c;
    assign mem.adrsrc   = adrsrc_c;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Outputs are packed into one vector and compared per cycle.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [2:0] immsrc;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .zero      (zero),
        .mem       (bus),
        .irwrite   (irwrite),
        .pcwrite   (pcwrite),
        .regwrite  (regwrite),
        .resultsrc (resultsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .immsrc    (immsrc),
        .illegal   (illegal)
    );

    // {mem_req,memwrite,adrsrc,irwrite,pcwrite,regwrite,
    //  resultsrc,alusrca,alusrcb,aluop,illegal}
    logic [14:0] outs;
    assign outs = {bus.mem_req, bus.memwrite, bus.adrsrc,
                   irwrite, pcwrite, regwrite,
                   resultsrc, alusrca, alusrcb, aluop, illegal};

    localparam logic [14:0] E_RESET     = 15'b0_0_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] E_FETCH_RDY = 15'b1_0_0_1_1_0_10_00_10_00_0;
    localparam logic [14:0] E_FETCH_WT  = 15'b1_0_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] E_DECODE    = 15'b0_0_0_0_0_0_00_01_01_00_0;
    localparam logic [14:0] E_MEMADR    = 15'b0_0_0_0_0_0_00_10_01_00_0;
    localparam logic [14:0] E_MEMREAD   = 15'b1_0_1_0_0_0_00_00_00_00_0;
    localparam logic [14:0] E_MEMWB     = 15'b0_0_0_0_0_1_01_00_00_00_0;
    localparam logic [14:0] E_MEMWRITE  = 15'b1_1_1_0_0_0_00_00_00_00_0;
    localparam logic [14:0] E_EXR       = 15'b0_0_0_0_0_0_00_10_00_10_0;
    localparam logic [14:0] E_EXI       = 15'b0_0_0_0_0_0_00_10_01_10_0;
    localparam logic [14:0] E_ALUWB     = 15'b0_0_0_0_0_1_00_00_00_00_0;
    localparam logic [14:0] E_BR_T      = 15'b0_0_0_0_1_0_00_10_00_01_0;
    localparam logic [14:0] E_BR_N      = 15'b0_0_0_0_0_0_00_10_00_01_0;
    localparam logic [14:0] E_JAL       = 15'b0_0_0_0_1_0_00_01_10_00_0;
    localparam logic [14:0] E_JALRADR   = 15'b0_0_0_0_0_0_00_10_01_00_0;
    localparam logic [14:0] E_HALT      = 15'b0_0_0_0_0_0_00_00_00_00_1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        op = 7'b0010011;
        funct3 = 3'b000;
        funct7b5 = 1'b0;
        zero = 1'b0;
        #1;
        repeat (2) tick;
        checks++;
        if (outs !== E_RESET) begin
            errors++;
            $display("FAIL reset_outs: got %b want %b", outs, E_RESET);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== E_FETCH_RDY) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", outs, E_FETCH_RDY);
        end
    endtask

    task automatic test_addi;
        logic [14:0] exp [5];
        exp = '{E_FETCH_RDY, E_DECODE, E_EXI, E_ALUWB, E_FETCH_RDY};
        op = 7'b0010011;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick;
            #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL addi step %0d: got %b want %b", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_rtype;
        logic [14:0] exp [5];
        exp = '{E_FETCH_RDY, E_DECODE, E_EXR, E_ALUWB, E_FETCH_RDY};
        op = 7'b0110011;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick;
            #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL rtype step %0d: got %b want %b", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_lw_wait;
        logic [14:0] exp [9];
        logic        rdy [9];
        exp = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMREAD,
                E_MEMREAD, E_MEMREAD, E_MEMWB, E_FETCH_RDY};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b1, 1'b1};
        op = 7'b0000011;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick;
            bus.mem_ready = rdy[i];
            #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL lw step %0d: got %b want %b", i, outs, exp[i]);
            end
            if (i == 1) begin
                checks++;
                if (immsrc !== 3'b000) begin
                    errors++;
                    $display("FAIL lw immsrc: got %b want 000", immsrc);
                end
            end
        end
    endtask

    task automatic test_sw_wait;
        logic [14:0] exp [6];
        logic        rdy [6];
        exp = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMWRITE,
                E_MEMWRITE, E_FETCH_RDY};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        op = 7'b0100011;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick;
            bus.mem_ready = rdy[i];
            #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL sw step %0d: got %b want %b", i, outs, exp[i]);
            end
            if (i == 1) begin
                checks++;
                if (immsrc !== 3'b001) begin
                    errors++;
                    $display("FAIL sw immsrc: got %b want 001", immsrc);
                end
            end
        end
    endtask

    task automatic test_branch;
        logic [2:0] f3 [4];
        logic       zf [4];
        logic       tk [4];
        logic [14:0] e;
        f3 = '{3'b000, 3'b000, 3'b001, 3'b001};
        zf = '{1'b1, 1'b0, 1'b0, 1'b1};
        tk = '{1'b1, 1'b0, 1'b1, 1'b0};
        op = 7'b1100011;
        bus.mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            funct3 = f3[c];
            zero = zf[c];
            e = tk[c] ? E_BR_T : E_BR_N;
            #1;
            checks++;
            if (outs !== E_FETCH_RDY) begin
                errors++;
                $display("FAIL br%0d fetch: got %b want %b", c, outs, E_FETCH_RDY);
            end
            tick;
            checks++;
            if (immsrc !== 3'b010) begin
                errors++;
                $display("FAIL br%0d immsrc: got %b want 010", c, immsrc);
            end
            tick;
            checks++;
            if (outs !== e) begin
                errors++;
                $display("FAIL br%0d branch: got %b want %b", c, outs, e);
            end
            tick;
        end
        funct3 = 3'b000;
        zero = 1'b0;
        #1;
        checks++;
        if (outs !== E_FETCH_RDY) begin
            errors++;
            $display("FAIL br_return: got %b want %b", outs, E_FETCH_RDY);
        end
    endtask

    task automatic test_jal;
        logic [14:0] exp [5];
        exp = '{E_FETCH_RDY, E_DECODE, E_JAL, E_ALUWB, E_FETCH_RDY};
        op = 7'b1101111;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick;
            #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL jal step %0d: got %b want %b", i, outs, exp[i]);
            end
            if (i == 1) begin
                checks++;
                if (immsrc !== 3'b011) begin
                    errors++;
                    $display("FAIL jal immsrc: got %b want 011", immsrc);
                end
            end
        end
    endtask

    task automatic test_fetch_wait;
        op = 7'b0010011;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick;
            #1;
            checks++;
            if (outs !== E_FETCH_WT) begin
                errors++;
                $display("FAIL fetch_wait %0d: got %b want %b", i, outs, E_FETCH_WT);
            end
        end
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (outs !== E_FETCH_RDY) begin
            errors++;
            $display("FAIL fetch_go: got %b want %b", outs, E_FETCH_RDY);
        end
    endtask

    task automatic test_halt;
        op = 7'h7F;
        bus.mem_ready = 1'b1;
        tick;
        #1;
        checks++;
        if (outs !== E_DECODE) begin
            errors++;
            $display("FAIL halt decode: got %b want %b", outs, E_DECODE);
        end
        for (int i = 0; i < 12; i++) begin
            tick;
            bus.mem_ready = i[0];
            zero = ~i[0];
            #1;
            checks++;
            if (outs !== E_HALT) begin
                errors++;
                $display("FAIL halt hold %0d: got %b want %b", i, outs, E_HALT);
            end
        end
        zero = 1'b0;
        bus.mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== E_RESET) begin
            errors++;
            $display("FAIL halt reset: got %b want %b", outs, E_RESET);
        end
        tick;
        reset = 1'b0;
        op = 7'b0010011;
        #1;
        checks++;
        if (outs !== E_FETCH_RDY) begin
            errors++;
            $display("FAIL halt recover: got %b want %b", outs, E_FETCH_RDY);
        end
    endtask

    task automatic test_reset_midop;
        logic [14:0] exp [4];
        logic        rdy [4];
        exp = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMREAD};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
        op = 7'b0000011;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            bus.mem_ready = rdy[i];
            #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL midrst step %0d: got %b want %b", i, outs, exp[i]);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== E_RESET) begin
            errors++;
            $display("FAIL midrst abandon: got %b want %b", outs, E_RESET);
        end
        tick;
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== E_FETCH_WT) begin
            errors++;
            $display("FAIL midrst fetch: got %b want %b", outs, E_FETCH_WT);
        end
        bus.mem_ready = 1'b1;
        #1;
    endtask

    task automatic test_jalr;
`ifdef CTRL_JALR_EN
        logic [14:0] exp [6];
        exp = '{E_FETCH_RDY, E_DECODE, E_JALRADR, E_JAL, E_ALUWB, E_FETCH_RDY};
        op = 7'b1100111;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick;
            #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL jalr step %0d: got %b want %b", i, outs, exp[i]);
            end
        end
`else
        logic [14:0] exp [4];
        exp = '{E_FETCH_RDY, E_DECODE, E_HALT, E_HALT};
        op = 7'b1100111;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL jalr step %0d: got %b want %b", i, outs, exp[i]);
            end
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
`endif
        checks++;
        if (immsrc !== 3'b000) begin
            errors++;
            $display("FAIL jalr immsrc: got %b want 000", immsrc);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype();
        test_lw_wait();
        test_sw_wait();
        test_branch();
        test_jal();
        test_fetch_wait();
        test_halt();
        test_reset_midop();
        test_jalr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
